iir_biquad_mc: RTL and testbench

IIR_BIQUAD_MC -- requirements
Module: iir_biquad_mc

---
 rtl/iir_pkg.sv | 24 ++
 rtl/iir_mac.sv | 53 +++++
 rtl/iir_biquad_mc.sv | 156 +++++++++++++++
 tb/tb_iir_biquad_mc.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// iir_pkg: shared coefficient-select codes and the
// coefficient record used by the multichannel biquad.
package iir_pkg;

   // Coefficients are held sign-extended to a fixed container width
   localparam int CMAX = 32;

   typedef enum logic [2:0] {
      SEL_B0 = 3'd0,
      SEL_B1 = 3'd1,
      SEL_B2 = 3'd2,
      SEL_A1 = 3'd3,
      SEL_A2 = 3'd4
   } coef_sel_e;

   typedef struct packed {
      logic signed [CMAX-1:0] b0;
      logic signed [CMAX-1:0] b1;
      logic signed [CMAX-1:0] b2;
      logic signed [CMAX-1:0] a1;
      logic signed [CMAX-1:0] a2;
   } coef_t;

endpackage

// File: rtl/iir_mac.sv
// iir_mac: five-term biquad multiply-accumulate with
// arithmetic shift and saturation, purely combinational.
module iir_mac
   import iir_pkg::*;
#(
   parameter int W    = 12,
   parameter int CW   = 12,
   parameter int FRAC = 10
) (
   input  logic signed [W-1:0] x0,
   input  logic signed [W-1:0] x1,
   input  logic signed [W-1:0] x2,
   input  logic signed [W-1:0] y1,
   input  logic signed [W-1:0] y2,
   input  coef_t               c,
   output logic signed [W-1:0] y
);

   localparam int AW = W + CW + 3;

   localparam logic signed [AW-1:0] HI =
      {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] LO =
      {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sh;

   // Coefficient values fit in CW bits, so the AW-bit product is exact
   function automatic logic signed [AW-1:0] mul(
      input logic signed [W-1:0]    s,
      input logic signed [CMAX-1:0] k
   );
      return AW'(s) * AW'(k);
   endfunction

   always_comb begin
      acc = mul(x0, $signed(c.b0))
          + mul(x1, $signed(c.b1))
          + mul(x2, $signed(c.b2))
          - mul(y1, $signed(c.a1))
          - mul(y2, $signed(c.a2));
      sh = acc >>> FRAC;
      if (sh > HI) begin
         y = W'(HI);
      end else if (sh < LO) begin
         y = W'(LO);
      end else begin
         y = W'(sh);
      end
   end

endmodule

// File: rtl/iir_biquad_mc.sv
// iir_biquad_mc: channel-interleaved direct-form-I biquad,
// one sample per cycle, two-cycle latency, shared coefficients.
module iir_biquad_mc
   import iir_pkg::*;
#(
   parameter int W    = 12,
   parameter int CW   = 12,
   parameter int FRAC = 10,
   parameter int N_CH = 4,
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [W-1:0]  din,
   input  logic                 vin,
   input  logic [CHW-1:0]       ch_in,
   input  logic                 bypass,
   input  logic                 clr,
   input  logic                 coef_we,
   input  logic [2:0]           coef_sel,
   input  logic signed [CW-1:0] coef_data,
   output logic signed [W-1:0]  dout,
   output logic                 vout,
   output logic [CHW-1:0]       ch_out
);

   logic signed [CMAX-1:0] cext;
   coef_t                  coef_q;
   logic                   accept;

   logic                   s1_v;
   logic                   s1_byp;
   logic [CHW-1:0]         s1_ch;
   logic signed [W-1:0]    s1_x;
   coef_t                  s1_c;

   logic signed [W-1:0]    hx1 [N_CH];
   logic signed [W-1:0]    hx2 [N_CH];
   logic signed [W-1:0]    hy1 [N_CH];
   logic signed [W-1:0]    hy2 [N_CH];

   logic signed [W-1:0]    rx1;
   logic signed [W-1:0]    rx2;
   logic signed [W-1:0]    ry1;
   logic signed [W-1:0]    ry2;
   logic signed [W-1:0]    mac_y;
   logic signed [W-1:0]    yn;

   logic                   s2_v;
   logic [CHW-1:0]         s2_ch;
   logic signed [W-1:0]    s2_y;

   assign cext   = CMAX'(coef_data);
   assign accept = vin && (int'(ch_in) < N_CH) && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_q <= '0;
      end else if (coef_we) begin
         case (coef_sel)
            SEL_B0:  coef_q.b0 <= cext;
            SEL_B1:  coef_q.b1 <= cext;
            SEL_B2:  coef_q.b2 <= cext;
            SEL_A1:  coef_q.a1 <= cext;
            SEL_A2:  coef_q.a2 <= cext;
            default: ;
         endcase
      end
   end

   // Capture stage snapshots coefficients so in-flight samples keep them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s1_byp <= 1'b0;
         s1_ch  <= '0;
         s1_x   <= '0;
         s1_c   <= '0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_byp <= bypass;
            s1_ch  <= ch_in;
            s1_x   <= din;
            s1_c   <= coef_q;
         end
      end
   end

   assign rx1 = hx1[s1_ch];
   assign rx2 = hx2[s1_ch];
   assign ry1 = hy1[s1_ch];
   assign ry2 = hy2[s1_ch];

   iir_mac #(
      .W    (W),
      .CW   (CW),
      .FRAC (FRAC)
   ) u_mac (
      .x0 (s1_x),
      .x1 (rx1),
      .x2 (rx2),
      .y1 (ry1),
      .y2 (ry2),
      .c  (s1_c),
      .y  (mac_y)
   );

   assign yn = s1_byp ? s1_x : mac_y;

   // History lands at the same edge a same-channel successor is captured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            hx1[i] <= '0;
            hx2[i] <= '0;
            hy1[i] <= '0;
            hy2[i] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < N_CH; i++) begin
            hx1[i] <= '0;
            hx2[i] <= '0;
            hy1[i] <= '0;
            hy2[i] <= '0;
         end
      end else if (s1_v) begin
         hx1[s1_ch] <= s1_x;
         hx2[s1_ch] <= rx1;
         hy1[s1_ch] <= yn;
         hy2[s1_ch] <= ry1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v   <= 1'b0;
         s2_ch  <= '0;
         s2_y   <= '0;
         vout   <= 1'b0;
         ch_out <= '0;
         dout   <= '0;
      end else if (clr) begin
         s2_v <= 1'b0;
         vout <= 1'b0;
      end else begin
         s2_v   <= s1_v;
         s2_ch  <= s1_ch;
         s2_y   <= yn;
         vout   <= s2_v;
         ch_out <= s2_ch;
         dout   <= s2_y;
      end
   end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Bench for iir_biquad_mc: directed and random stimulus
// checked against a per-channel difference-equation model.
module tb_iir_biquad_mc;

   localparam int W    = 12;
   localparam int CW   = 12;
   localparam int FRAC = 10;
   localparam int N_CH = 5;
   localparam int CHW  = 3;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic signed [W-1:0]  din = '0;
   logic                 vin = 1'b0;
   logic [CHW-1:0]       ch_in = '0;
   logic                 bypass = 1'b0;
   logic                 clr = 1'b0;
   logic                 coef_we = 1'b0;
   logic [2:0]           coef_sel = '0;
   logic signed [CW-1:0] coef_data = '0;
   logic signed [W-1:0]  dout;
   logic                 vout;
   logic [CHW-1:0]       ch_out;

   iir_biquad_mc #(
      .W    (W),
      .CW   (CW),
      .FRAC (FRAC),
      .N_CH (N_CH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .vin       (vin),
      .ch_in     (ch_in),
      .bypass    (bypass),
      .clr       (clr),
      .coef_we   (coef_we),
      .coef_sel  (coef_sel),
      .coef_data (coef_data),
      .dout      (dout),
      .vout      (vout),
      .ch_out    (ch_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int y;
      int due;
   } exp_t;

   exp_t q[$];
   int   mx1 [N_CH];
   int   mx2 [N_CH];
   int   my1 [N_CH];
   int   my2 [N_CH];
   int   cb  [5];
   int   dl_d[$];
   int   dl_c[$];
   int   ml_d[$];
   int   ml_c[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int sat(longint v);
      if (v > 2047) return 2047;
      if (v < -2048) return -2048;
      return int'(v);
   endfunction

   task automatic zero_hist();
      for (int i = 0; i < N_CH; i++) begin
         mx1[i] = 0;
         mx2[i] = 0;
         my1[i] = 0;
         my2[i] = 0;
      end
   endtask

   // y = b0 x + b1 x' + b2 x'' - a1 y' - a2 y'' , floor by 2^FRAC
   task automatic model_edge();
      int     c;
      int     y;
      longint acc;
      c = int'(ch_in);
      if (clr) begin
         zero_hist();
         q.delete();
      end else if (vin && c < N_CH) begin
         if (bypass) begin
            y = int'(din);
         end else begin
            acc = longint'(cb[0]) * longint'(din)
                + longint'(cb[1]) * mx1[c]
                + longint'(cb[2]) * mx2[c]
                - longint'(cb[3]) * my1[c]
                - longint'(cb[4]) * my2[c];
            y = sat(acc >>> FRAC);
         end
         mx2[c] = mx1[c];
         mx1[c] = int'(din);
         my2[c] = my1[c];
         my1[c] = y;
         q.push_back('{c, y, cyc + 2});
         ml_d.push_back(y);
         ml_c.push_back(c);
      end
      if (coef_we && coef_sel < 3'd5) cb[coef_sel] = int'(coef_data);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst_n) model_edge();
      #1;
      vin = 1'b0;
      clr = 1'b0;
      coef_we = 1'b0;
      bypass = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic send(int c, int d);
      vin = 1'b1;
      ch_in = CHW'(c);
      din = W'(d);
      tick();
   endtask

   task automatic wr(int sel, int v);
      coef_we = 1'b1;
      coef_sel = 3'(sel);
      coef_data = CW'(v);
      tick();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
   endtask

   task automatic clear_logs();
      dl_d.delete();
      dl_c.delete();
      ml_d.delete();
      ml_c.delete();
   endtask

   function automatic int nth(int which, int ch, int n);
      int k = 0;
      if (which == 0) begin
         foreach (dl_d[i]) if (dl_c[i] == ch) begin
            if (k == n) return dl_d[i];
            k++;
         end
      end else begin
         foreach (ml_d[i]) if (ml_c[i] == ch) begin
            if (k == n) return ml_d[i];
            k++;
         end
      end
      return 99999;
   endfunction

   task automatic lit(string nm, int ch, int n, int exp);
      chk({nm, "_dut"}, nth(0, ch, n), exp);
      chk({nm, "_model"}, nth(1, ch, n), exp);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_vout", int'(vout), 0);
         chk("rst_dout", int'(dout), 0);
         chk("rst_ch_out", int'(ch_out), 0);
      end else if (q.size() > 0 && q[0].due == cyc) begin
         chk("vout", int'(vout), 1);
         chk("dout", int'(dout), q[0].y);
         chk("ch_out", int'(ch_out), q[0].ch);
         if (vout) begin
            dl_d.push_back(int'(dout));
            dl_c.push_back(int'(ch_out));
         end
         void'(q.pop_front());
      end else begin
         chk("vout_idle", int'(vout), 0);
      end
   end

   initial begin
      int sel;
      int cd;
      zero_hist();
      for (int i = 0; i < 5; i++) cb[i] = 0;

      idle(2);
      #2 rst_n = 1'b1;

      clear_logs();
      send(0, 500);
      idle(3);
      lit("zero_coef", 0, 0, 0);

      wr(0, 1024);
      clear_logs();
      send(0, 1000);
      idle(3);
      lit("unity", 0, 0, 1000);

      do_clr();
      wr(3, -512);
      clear_logs();
      send(0, 1000);
      repeat (3) send(0, 0);
      idle(3);
      lit("decay0", 0, 0, 1000);
      lit("decay1", 0, 1, 500);
      lit("decay2", 0, 2, 250);
      lit("decay3", 0, 3, 125);

      do_clr();
      wr(0, 2047);
      wr(3, 0);
      clear_logs();
      send(0, 2047);
      send(0, -2048);
      idle(3);
      lit("sat_hi", 0, 0, 2047);
      lit("sat_lo", 0, 1, -2048);

      do_clr();
      wr(0, 1024);
      wr(1, 256);
      wr(3, -512);
      clear_logs();
      for (int r = 0; r < 6; r++) begin
         send(0, r == 0 ? 1000 : 0);
         send(1, r == 0 ? 1000 : 0);
         send(1, 0);
         send(2, r == 0 ? 1000 : 0);
         send(3, r == 0 ? 1000 : 0);
      end
      idle(3);
      lit("ilv_ch0_0", 0, 0, 1000);
      lit("ilv_ch0_1", 0, 1, 750);
      lit("ilv_ch0_2", 0, 2, 375);
      lit("ilv_ch0_3", 0, 3, 187);
      lit("ilv_ch1_b2b", 1, 1, 750);

      do_clr();
      clear_logs();
      bypass = 1'b1;
      send(2, -300);
      send(2, 0);
      idle(3);
      lit("bypass", 2, 0, -300);
      lit("after_bypass", 2, 1, -225);

      clear_logs();
      send(5, 1000);
      send(7, 1000);
      send(4, 1000);
      idle(3);
      lit("bad_ch_ignored", 4, 0, 1000);

      send(0, 1000);
      send(0, 0);
      clr = 1'b1;
      vin = 1'b1;
      ch_in = '0;
      din = W'(1234);
      tick();
      clear_logs();
      send(0, 1000);
      send(0, 0);
      idle(3);
      lit("clr_restart0", 0, 0, 1000);
      lit("clr_restart1", 0, 1, 750);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            sel = int'($urandom_range(0, 7));
            if (sel >= 3) cd = int'($urandom_range(0, 1400)) - 700;
            else cd = int'($urandom_range(0, 4095)) - 2048;
            coef_we = 1'b1;
            coef_sel = 3'(sel);
            coef_data = CW'(cd);
         end
         vin = ($urandom_range(0, 3) != 0);
         ch_in = CHW'($urandom_range(0, 7));
         din = W'($urandom_range(0, 4095));
         bypass = ($urandom_range(0, 9) == 0);
         clr = ($urandom_range(0, 199) == 0);
         tick();
      end

      wr(0, 1024);
      wr(1, 512);
      send(3, 900);
      send(1, 1000);
      send(2, 500);
      #2 rst_n = 1'b0;
      #1;
      chk("async_vout", int'(vout), 0);
      chk("async_dout", int'(dout), 0);
      q.delete();
      zero_hist();
      for (int i = 0; i < 5; i++) cb[i] = 0;
      send(0, 100);
      send(3, 100);
      #2 rst_n = 1'b1;
      clear_logs();
      send(0, 777);
      idle(3);
      lit("post_rst_coef", 0, 0, 0);
      wr(0, 1024);
      wr(1, 512);
      clear_logs();
      send(3, 1000);
      idle(3);
      lit("post_rst_hist", 3, 0, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
